// File: rtl/processor_sr_gen.sv
// Shift-register microsequencer for the EC point datapath. It keeps a rotating ring of
// registers, runs a ROM program, executes MOV/TSTZ itself and hands other ops to external units.
module processor_sr_gen #(
  parameter int W          = 224,
  parameter int REG_BITS   = 3,
  parameter int IADDR_BITS = 8,
  parameter int N_IN       = 4,
  parameter int N_OUT      = 2,
  parameter int WDOG_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_IN*W-1:0]     data_in,
  output logic [IADDR_BITS-1:0] instr_addr,
  input  logic [2*REG_BITS+1:0] instruction,
  output logic [REG_BITS-1:0]   au_op,
  output logic                  au_start,
  output logic [W-1:0]          au_a,
  output logic [W-1:0]          au_b,
  input  logic [W-1:0]          au_result,
  input  logic                  au_done,
  output logic [N_OUT*W-1:0]    results,
  output logic                  busy,
  output logic                  done,
  output logic                  succeed,
  output logic                  err
);
  localparam int NREGS = 1 << REG_BITS;
  localparam int OFF_W = 2 * REG_BITS;
  localparam logic [REG_BITS-1:0]   OP_MOV    = REG_BITS'(3);
  localparam logic [REG_BITS-1:0]   OP_TSTZ   = REG_BITS'(4);
  localparam logic [REG_BITS-1:0]   COLL_LAST = REG_BITS'(N_OUT - 1);
  localparam logic [REG_BITS-1:0]   ID_ONE    = REG_BITS'(1);
  localparam logic [IADDR_BITS-1:0] ADDR_ONE  = IADDR_BITS'(1);
  localparam logic [WDOG_BITS-1:0]  WD_ONE    = WDOG_BITS'(1);
  // Last EXEC cycle before the counter would reach its all-ones value.
  localparam logic [WDOG_BITS-1:0]  WD_LAST   = {{(WDOG_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_LOAD_OP, S_EXEC, S_WRITEBACK, S_COLLECT, S_DONE
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [REG_BITS-1:0]   sr_id_r;
  logic [W-1:0]          ring_r [NREGS];
  logic [W-1:0]          load_val_s [NREGS];
  logic [W-1:0]          tap_s;
  logic [IADDR_BITS-1:0] instr_addr_r, addr_nxt_s;
  logic                  zf_r, zf_nxt_s;
  logic [REG_BITS-1:0]   op1_sel_r, op1_sel_nxt_s, op2_sel_r, op2_sel_nxt_s;
  logic [REG_BITS-1:0]   op_r, op_nxt_s, dest_r, dest_nxt_s;
  logic [W-1:0]          op1_r, op1_nxt_s, result_r, result_nxt_s;
  logic                  got_op1_r, got_op1_nxt_s;
  logic [WDOG_BITS-1:0]  wd_r, wd_nxt_s;
  logic [REG_BITS-1:0]   coll_cnt_r, coll_nxt_s;
  logic                  au_start_r, au_start_nxt_s;
  logic [REG_BITS-1:0]   au_op_r, au_op_nxt_s;
  logic [W-1:0]          au_a_r, au_a_nxt_s, au_b_r, au_b_nxt_s;
  logic                  succeed_r, succeed_nxt_s, err_r, err_nxt_s;
  logic [W-1:0]          results_r [N_OUT];
  logic                  load_s, wr_s, cap_s;

  logic [1:0]            ityp_s;
  logic [REG_BITS-1:0]   v0_s, v1_s;
  logic [OFF_W-1:0]      off_s;
  logic [IADDR_BITS-1:0] off_ext_s;
  logic                  jmp_taken_s;

  assign ityp_s      = instruction[OFF_W +: 2];
  assign v0_s        = instruction[REG_BITS +: REG_BITS];
  assign v1_s        = instruction[REG_BITS-1:0];
  assign off_s       = instruction[OFF_W-1:0];
  assign off_ext_s   = IADDR_BITS'($signed(off_s));
  // JZ (type bit 0 clear) jumps on ZF=1, JNZ jumps on ZF=0.
  assign jmp_taken_s = ityp_s[0] ^ zf_r;
  assign tap_s       = ring_r[0];

  // Preload image: ring position p holds logical register sr_id+1+p after the load edge.
  always_comb begin
    for (int p = 0; p < NREGS; p++) begin
      load_val_s[p] = {W{1'b0}};
      for (int i = 0; i < N_IN; i++) begin
        load_val_s[p] = ((sr_id_r + REG_BITS'(p + 1)) == REG_BITS'(i)) ?
                        data_in[i*W +: W] : load_val_s[p];
      end
    end
  end

  // Next-state and datapath control for the sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    addr_nxt_s     = instr_addr_r;
    zf_nxt_s       = zf_r;
    op1_sel_nxt_s  = op1_sel_r;
    op2_sel_nxt_s  = op2_sel_r;
    op_nxt_s       = op_r;
    dest_nxt_s     = dest_r;
    op1_nxt_s      = op1_r;
    got_op1_nxt_s  = got_op1_r;
    result_nxt_s   = result_r;
    wd_nxt_s       = wd_r;
    coll_nxt_s     = coll_cnt_r;
    au_start_nxt_s = 1'b0;
    au_op_nxt_s    = au_op_r;
    au_a_nxt_s     = au_a_r;
    au_b_nxt_s     = au_b_r;
    succeed_nxt_s  = succeed_r;
    err_nxt_s      = err_r;
    load_s         = 1'b0;
    wr_s           = 1'b0;
    cap_s          = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          load_s        = 1'b1;
          addr_nxt_s    = {IADDR_BITS{1'b0}};
          zf_nxt_s      = 1'b1;
          succeed_nxt_s = 1'b0;
          err_nxt_s     = 1'b0;
          state_nxt_s   = S_DECODE;
        end else begin
          state_nxt_s   = state_r;
        end
      end
      S_DECODE: begin
        case (ityp_s)
          2'b00: begin
            op1_sel_nxt_s = v0_s;
            op2_sel_nxt_s = v1_s;
            addr_nxt_s    = instr_addr_r + ADDR_ONE;
          end
          2'b01: begin
            op_nxt_s      = v0_s;
            dest_nxt_s    = v1_s;
            got_op1_nxt_s = 1'b0;
            state_nxt_s   = S_LOAD_OP;
          end
          default: begin
            if (off_s == {OFF_W{1'b0}}) begin
              succeed_nxt_s = ityp_s[0];
              coll_nxt_s    = {REG_BITS{1'b0}};
              state_nxt_s   = S_COLLECT;
            end else if (jmp_taken_s) begin
              addr_nxt_s    = instr_addr_r + off_ext_s;
            end else begin
              addr_nxt_s    = instr_addr_r + ADDR_ONE;
            end
          end
        endcase
      end
      S_LOAD_OP: begin
        // got_op1 is registered, so op2 is always taken in a later cycle than op1.
        if (!got_op1_r) begin
          if (sr_id_r == op1_sel_r) begin
            op1_nxt_s     = tap_s;
            got_op1_nxt_s = 1'b1;
          end else begin
            got_op1_nxt_s = 1'b0;
          end
        end else if (sr_id_r == op2_sel_r) begin
          wd_nxt_s    = {WDOG_BITS{1'b0}};
          state_nxt_s = S_EXEC;
          if ((op_r != OP_MOV) && (op_r != OP_TSTZ)) begin
            au_start_nxt_s = 1'b1;
            au_op_nxt_s    = op_r;
            au_a_nxt_s     = op1_r;
            au_b_nxt_s     = tap_s;
          end else begin
            au_start_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = S_LOAD_OP;
        end
      end
      S_EXEC: begin
        case (op_r)
          OP_MOV: begin
            result_nxt_s = op1_r;
            state_nxt_s  = S_WRITEBACK;
          end
          OP_TSTZ: begin
            zf_nxt_s    = (op1_r == {W{1'b0}});
            addr_nxt_s  = instr_addr_r + ADDR_ONE;
            state_nxt_s = S_DECODE;
          end
          default: begin
            if (au_done) begin
              result_nxt_s  = au_result;
              state_nxt_s   = S_WRITEBACK;
            end else if (wd_r == WD_LAST) begin
              err_nxt_s     = 1'b1;
              succeed_nxt_s = 1'b0;
              state_nxt_s   = S_DONE;
            end else begin
              wd_nxt_s      = wd_r + WD_ONE;
            end
          end
        endcase
      end
      S_WRITEBACK: begin
        if (sr_id_r == dest_r) begin
          wr_s        = 1'b1;
          addr_nxt_s  = instr_addr_r + ADDR_ONE;
          state_nxt_s = S_DECODE;
        end else begin
          state_nxt_s = S_WRITEBACK;
        end
      end
      S_COLLECT: begin
        if ((coll_cnt_r == {REG_BITS{1'b0}}) && (sr_id_r != {REG_BITS{1'b0}})) begin
          state_nxt_s = S_COLLECT;
        end else begin
          cap_s = 1'b1;
          if (coll_cnt_r == COLL_LAST) begin
            state_nxt_s = S_DONE;
          end else begin
            coll_nxt_s  = coll_cnt_r + ID_ONE;
          end
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Register ring: rotates every cycle, write slips in at the tail when the tap shows dest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_id_r <= {REG_BITS{1'b0}};
      for (int p = 0; p < NREGS; p++) ring_r[p] <= {W{1'b0}};
    end else begin
      sr_id_r <= sr_id_r + ID_ONE;
      if (load_s) begin
        for (int p = 0; p < NREGS; p++) ring_r[p] <= load_val_s[p];
      end else begin
        for (int p = 0; p < NREGS - 1; p++) ring_r[p] <= ring_r[p+1];
        ring_r[NREGS-1] <= wr_s ? result_r : tap_s;
      end
    end
  end

  // Sequencer state, operand latches and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      instr_addr_r <= {IADDR_BITS{1'b0}};
      zf_r         <= 1'b1;
      op1_sel_r    <= {REG_BITS{1'b0}};
      op2_sel_r    <= {REG_BITS{1'b0}};
      op_r         <= {REG_BITS{1'b0}};
      dest_r       <= {REG_BITS{1'b0}};
      op1_r        <= {W{1'b0}};
      got_op1_r    <= 1'b0;
      result_r     <= {W{1'b0}};
      wd_r         <= {WDOG_BITS{1'b0}};
      coll_cnt_r   <= {REG_BITS{1'b0}};
      au_start_r   <= 1'b0;
      au_op_r      <= {REG_BITS{1'b0}};
      au_a_r       <= {W{1'b0}};
      au_b_r       <= {W{1'b0}};
      succeed_r    <= 1'b0;
      err_r        <= 1'b0;
      for (int k = 0; k < N_OUT; k++) results_r[k] <= {W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      instr_addr_r <= addr_nxt_s;
      zf_r         <= zf_nxt_s;
      op1_sel_r    <= op1_sel_nxt_s;
      op2_sel_r    <= op2_sel_nxt_s;
      op_r         <= op_nxt_s;
      dest_r       <= dest_nxt_s;
      op1_r        <= op1_nxt_s;
      got_op1_r    <= got_op1_nxt_s;
      result_r     <= result_nxt_s;
      wd_r         <= wd_nxt_s;
      coll_cnt_r   <= coll_nxt_s;
      au_start_r   <= au_start_nxt_s;
      au_op_r      <= au_op_nxt_s;
      au_a_r       <= au_a_nxt_s;
      au_b_r       <= au_b_nxt_s;
      succeed_r    <= succeed_nxt_s;
      err_r        <= err_nxt_s;
      for (int k = 0; k < N_OUT; k++) begin
        if (cap_s && (coll_cnt_r == REG_BITS'(k))) results_r[k] <= tap_s;
      end
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_res
    assign results[k*W +: W] = results_r[k];
  end

  assign instr_addr = instr_addr_r;
  assign au_op      = au_op_r;
  assign au_start   = au_start_r;
  assign au_a       = au_a_r;
  assign au_b       = au_b_r;
  assign succeed    = succeed_r;
  assign err        = err_r;
  assign done       = (state_r == S_DONE);
  assign busy       = (state_r != S_IDLE) && (state_r != S_DONE);

endmodule

// File: tb/tb_processor_sr_gen.sv
// Scoreboard bench for processor_sr_gen: directed ROM programs, expected halt results
// and arithmetic-unit requests are queued and checked by independent monitor processes.
module tb_processor_sr_gen;
  localparam int W = 224, RB = 3, IAB = 8, NIN = 4, NOUT = 2, WDB = 4;

  typedef struct { logic s; logic e; logic [W-1:0] r0; logic [W-1:0] r1; } res_t;
  typedef struct { logic [RB-1:0] op; logic [W-1:0] a; logic [W-1:0] b; } au_t;

  logic clk = 1'b0;
  logic rst, start, au_start, au_done, busy, done, succeed, err;
  logic [NIN*W-1:0]  data_in;
  logic [IAB-1:0]    instr_addr;
  logic [2*RB+1:0]   instruction;
  logic [RB-1:0]     au_op;
  logic [W-1:0]      au_a, au_b, au_result;
  logic [NOUT*W-1:0] results;
  logic [7:0]        rom [256];

  res_t           res_q [$];
  au_t            au_q [$];
  logic [IAB-1:0] addr_q [$];
  int   vectors = 0;
  int   miscompares = 0;
  logic addr_chk = 1'b0;
  int   au_mode = 0;
  logic prev_done = 1'b0;
  logic [IAB-1:0] prev_addr = 8'd0;
  int   n;

  always #5 clk = ~clk;
  assign instruction = rom[instr_addr];

  processor_sr_gen #(.W(W), .REG_BITS(RB), .IADDR_BITS(IAB), .N_IN(NIN), .N_OUT(NOUT),
                     .WDOG_BITS(WDB)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .instr_addr(instr_addr),
    .instruction(instruction), .au_op(au_op), .au_start(au_start), .au_a(au_a), .au_b(au_b),
    .au_result(au_result), .au_done(au_done), .results(results), .busy(busy), .done(done),
    .succeed(succeed), .err(err));

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
  endtask

  function automatic logic [NIN*W-1:0] pack4(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c, input logic [W-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check_reset();
    chk("rst_instr_addr", W'(instr_addr), W'(0));
    chk("rst_au_start", W'(au_start), W'(0));
    chk("rst_au_a", au_a, W'(0));
    chk("rst_au_b", au_b, W'(0));
    chk("rst_results", results[W-1:0] | results[2*W-1:W], W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_succeed", W'(succeed), W'(0));
    chk("rst_err", W'(err), W'(0));
    chk("rst_busy", W'(busy), W'(0));
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run(input logic s, input logic e, input logic [W-1:0] r0, input logic [W-1:0] r1);
    int c;
    res_q.push_back('{s: s, e: e, r0: r0, r1: r1});
    pulse_start();
    chk("busy_running", W'(busy), W'(1));
    c = 0;
    while (!done && c < 4000) begin
      @(negedge clk);
      c++;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL run_timeout: got done=0 expected done=1 within 4000 cycles");
    end
    @(negedge clk);
  endtask

  // Halt-result and program-counter monitor.
  initial begin
    res_t e;
    logic [IAB-1:0] ea;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (res_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 expected no halt");
        end else begin
          e = res_q.pop_front();
          chk("succeed", W'(succeed), W'(e.s));
          chk("err", W'(err), W'(e.e));
          chk("result0", results[W-1:0], e.r0);
          chk("result1", results[2*W-1:W], e.r1);
        end
      end
      if (addr_chk && instr_addr != prev_addr) begin
        if (addr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_addr: got %0d expected no change", instr_addr);
        end else begin
          ea = addr_q.pop_front();
          chk("instr_addr", W'(instr_addr), W'(ea));
        end
      end
      prev_done = done;
      prev_addr = instr_addr;
    end
  end

  // Arithmetic-unit responder: mode 0 answers 0x1234 after 10 cycles, mode 1 never answers.
  initial begin
    au_t t;
    au_done = 1'b0;
    au_result = W'(0);
    forever begin
      @(negedge clk);
      if (au_start) begin
        if (au_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_au_start: got au_start=1 expected no request");
        end else begin
          t = au_q.pop_front();
          chk("au_op", W'(au_op), W'(t.op));
          chk("au_a", au_a, t.a);
          chk("au_b", au_b, t.b);
          if (au_mode == 0) begin
            for (int i = 0; i < 10; i++) begin
              @(negedge clk);
              chk("au_start_width", W'(au_start), W'(0));
              chk("au_a_stable", au_a, t.a);
              chk("au_b_stable", au_b, t.b);
            end
            au_result = W'(16'h1234);
            au_done = 1'b1;
            @(negedge clk);
            au_done = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    data_in = pack4(W'(5), W'(7), W'(0), W'(8'h33));
    rom_clear();
    #12;
    check_reset();
    @(negedge clk) rst = 1'b1;

    // MOV r1 -> r0, then JNZ 0 halts with success
    rom[0] = 8'h08; rom[1] = 8'h58; rom[2] = 8'hC0;
    run(1'b1, 1'b0, W'(7), W'(7));

    // TSTZ r2 with r2=0: JZ +2 taken, halt at 4 with success
    rom_clear();
    rom[0] = 8'h12; rom[1] = 8'h60; rom[2] = 8'h82; rom[3] = 8'h80; rom[4] = 8'hC0;
    addr_chk = 1'b1;
    addr_q.push_back(8'd0); addr_q.push_back(8'd1); addr_q.push_back(8'd2); addr_q.push_back(8'd4);
    run(1'b1, 1'b0, W'(5), W'(7));

    // Same program with r2=9: JZ not taken, JZ 0 halts with failure
    data_in = pack4(W'(5), W'(7), W'(9), W'(8'h33));
    addr_q.push_back(8'd0); addr_q.push_back(8'd1); addr_q.push_back(8'd2); addr_q.push_back(8'd3);
    run(1'b0, 1'b0, W'(5), W'(7));

    // Backward jumps: 3->0, JNZ -1 at 0 wraps to 255, +11 wraps to 10, JNZ -1 to 9
    rom_clear();
    rom[0] = 8'hFF; rom[1] = 8'h12; rom[2] = 8'h60; rom[3] = 8'hFD;
    rom[255] = 8'hCB; rom[10] = 8'hFF; rom[9] = 8'h80;
    addr_q.push_back(8'd0); addr_q.push_back(8'd1); addr_q.push_back(8'd2); addr_q.push_back(8'd3);
    addr_q.push_back(8'd0); addr_q.push_back(8'd255); addr_q.push_back(8'd10); addr_q.push_back(8'd9);
    run(1'b0, 1'b0, W'(5), W'(7));
    addr_chk = 1'b0;
    chk("addr_q_drained", W'(addr_q.size()), W'(0));

    // External op 1 on (r1, r0) into r1 with a delayed au_done
    rom_clear();
    rom[0] = 8'h08; rom[1] = 8'h49; rom[2] = 8'hC0;
    au_mode = 0;
    au_q.push_back('{op: 3'd1, a: W'(7), b: W'(5)});
    run(1'b1, 1'b0, W'(5), W'(16'h1234));

    // Asynchronous reset in the middle of EXEC, then a clean rerun
    au_mode = 1;
    au_q.push_back('{op: 3'd1, a: W'(7), b: W'(5)});
    pulse_start();
    n = 0;
    while (!au_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_exec_reached", W'(au_start), W'(1));
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset();
    @(negedge clk) rst = 1'b1;
    au_mode = 0;
    au_q.push_back('{op: 3'd1, a: W'(7), b: W'(5)});
    run(1'b1, 1'b0, W'(5), W'(16'h1234));

    // Watchdog abort after 15 EXEC cycles with no au_done
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    au_mode = 1;
    au_q.push_back('{op: 3'd1, a: W'(7), b: W'(5)});
    res_q.push_back('{s: 1'b0, e: 1'b1, r0: W'(0), r1: W'(0)});
    pulse_start();
    n = 0;
    while (!au_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wdog_exec_reached", W'(au_start), W'(1));
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wdog_cycles", W'(n), W'(15));
    chk("wdog_done", W'(done), W'(1));
    repeat (3) @(negedge clk);

    chk("res_q_drained", W'(res_q.size()), W'(0));
    chk("au_q_drained", W'(au_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
